// File: rtl/pipe_rca_addsub_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and slice width
//   mode_e                        : runtime add/sub encoding of the 'sub' input
//   fa()                          : one-bit full-adder cell used by the ripple slices
package pipe_rca_addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CHUNK = 8;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    typedef struct packed {
        logic co;
        logic s;
    } fa_t;

    function automatic fa_t fa(input logic a, input logic b, input logic ci);
        fa_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (a & ci) | (b & ci);
        return r;
    endfunction

endpackage

// File: rtl/pipe_rca_addsub_rca_n.sv
// rca_n: combinational N-bit ripple-carry slice built from the fa cell.
//   a, b   : N-bit operands
//   ci     : carry into bit 0
//   s      : N-bit sum
//   co     : carry out of bit N-1
//   c_msb  : carry into bit N-1 (paired with co to form signed overflow)
module rca_n
    import pipe_rca_addsub_pkg::*;
#(
    parameter int unsigned N = DEFAULT_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         co,
    output logic [N-1:0] s,
    output logic         c_msb
);

    logic [N:0] c;
    fa_t        bit_r;

    always_comb begin
        c     = '0;
        s     = '0;
        bit_r = '0;
        c[0]  = ci;
        for (int unsigned i = 0; i < N; i++) begin
            bit_r    = fa(a[i], b[i], c[i]);
            s[i]     = bit_r.s;
            c[i+1]   = bit_r.co;
        end
    end

    assign co    = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/pipe_rca_addsub.sv
// pipe_rca_addsub: pipelined WIDTH-bit ripple-carry adder/subtractor, one
// registered CHUNK-bit slice per stage, valid/ready handshake with whole-pipe stall.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid | out_ready)
//   a, b, ci, sub       : operands, carry-in (add only), 1 = subtract a-b
//   out_valid/out_ready : result handshake
//   s, co, ovf          : result, carry out of MSB, two's-complement overflow
module pipe_rca_addsub
    import pipe_rca_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipe_rca_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic adv;

    // Per-stage register outputs. a_p/b_p carry the operands forward (skew),
    // s_p accumulates finished result slices (deskew). b_p is already inverted
    // for subtraction, so the mode itself need not travel with the beat.
    logic             v_p   [STAGES];
    logic             cy_p  [STAGES];
    logic             ovf_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];

    mode_e            mode_in;
    logic [WIDTH-1:0] b_first;
    logic             c_first;

    assign mode_in = mode_e'(sub);
    assign b_first = (mode_in == MODE_SUB) ? ~b : b;
    assign c_first = (mode_in == MODE_SUB) ? 1'b1 : ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic [CHUNK-1:0] sl_s;
        logic             sl_co;
        logic             sl_cmsb;

        logic             v_q;
        logic             cy_q;
        logic             ovf_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_first
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = b_first;
            assign c_in = c_first;
            assign s_in = '0;
        end else begin : g_next
            assign v_in = v_p[k-1];
            assign a_in = a_p[k-1];
            assign b_in = b_p[k-1];
            assign c_in = cy_p[k-1];
            assign s_in = s_p[k-1];
        end

        rca_n #(.N(CHUNK)) u_rca (
            .a     (a_in[k*CHUNK +: CHUNK]),
            .b     (b_in[k*CHUNK +: CHUNK]),
            .ci    (c_in),
            .co    (sl_co),
            .s     (sl_s),
            .c_msb (sl_cmsb)
        );

        always_comb begin
            s_nx                    = s_in;
            s_nx[k*CHUNK +: CHUNK]  = sl_s;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q   <= 1'b0;
                cy_q  <= 1'b0;
                ovf_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                cy_q  <= sl_co;
                ovf_q <= sl_co ^ sl_cmsb;
                a_q   <= a_in;
                b_q   <= b_in;
                s_q   <= s_nx;
            end
        end

        assign v_p[k]   = v_q;
        assign cy_p[k]  = cy_q;
        assign ovf_p[k] = ovf_q;
        assign a_p[k]   = a_q;
        assign b_p[k]   = b_q;
        assign s_p[k]   = s_q;
    end

    assign out_valid = v_p[STAGES-1];
    assign s         = s_p[STAGES-1];
    assign co        = cy_p[STAGES-1];
    assign ovf       = ovf_p[STAGES-1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

endmodule

// File: tb/tb_pipe_rca_addsub.sv
module tb_pipe_rca_addsub;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // 32/8 instance
    logic        iv32, ir32, ov32, or32, ci32, sub32, co32, ovf32;
    logic [31:0] a32, b32, s32;
    // 16/16 instance
    logic        iv16, ir16, ov16, or16, ci16, sub16, co16, ovf16;
    logic [15:0] a16, b16, s16;
    // 12/3 instance
    logic        iv12, ir12, ov12, or12, ci12, sub12, co12, ovf12;
    logic [11:0] a12, b12, s12;

    pipe_rca_addsub #(.WIDTH(32), .CHUNK(8)) u_d32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .ci(ci32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32), .s(s32), .co(co32), .ovf(ovf32)
    );

    pipe_rca_addsub #(.WIDTH(16), .CHUNK(16)) u_d16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16), .ovf(ovf16)
    );

    pipe_rca_addsub #(.WIDTH(12), .CHUNK(3)) u_d12 (
        .clk(clk), .reset(reset), .in_valid(iv12), .in_ready(ir12),
        .a(a12), .b(b12), .ci(ci12), .sub(sub12),
        .out_valid(ov12), .out_ready(or12), .s(s12), .co(co12), .ovf(ovf12)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub, input logic ordy);
        case (sel)
            0: begin iv32 = v; a32 = a;        b32 = b;        ci32 = ci; sub32 = sub; or32 = ordy; end
            1: begin iv16 = v; a16 = a[15:0];  b16 = b[15:0];  ci16 = ci; sub16 = sub; or16 = ordy; end
            default: begin iv12 = v; a12 = a[11:0]; b12 = b[11:0]; ci12 = ci; sub12 = sub; or12 = ordy; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ov, output logic [31:0] s,
                          output logic co, output logic ovf, output logic ird);
        case (sel)
            0: begin ov = ov32; s = s32;           co = co32; ovf = ovf32; ird = ir32; end
            1: begin ov = ov16; s = {16'h0, s16};  co = co16; ovf = ovf16; ird = ir16; end
            default: begin ov = ov12; s = {20'h0, s12}; co = co12; ovf = ovf12; ird = ir12; end
        endcase
    endtask

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sub);
        logic [31:0] bb;
        logic [32:0] full;
        logic        v;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'h0, (sub ? 1'b1 : ci)};
        v    = (a[31] == bb[31]) && (full[31] != a[31]);
        return {full[31:0], full[32], v};
    endfunction

    task automatic one_beat(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sub, input int exp_lat,
                            input logic [31:0] exp_s, input logic exp_co, input logic exp_ovf);
        logic        ov, co, ovf, ird;
        logic [31:0] s;
        int          lat;
        @(negedge clk);
        drive(sel, 1'b1, a, b, ci, sub, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, a, b, ci, sub, 1'b1);
        lat = 1;
        sample(sel, ov, s, co, ovf, ird);
        while (!ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            sample(sel, ov, s, co, ovf, ird);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " s"}, {32'h0, s}, {32'h0, exp_s});
        check({tag, " co/ovf"}, {62'h0, co, ovf}, {62'h0, exp_co, exp_ovf});
        @(posedge clk);
        #1;
        sample(sel, ov, s, co, ovf, ird);
        check({tag, " drained"}, {63'h0, ov}, 64'h0);
    endtask

    logic [33:0] exp_q[$];

    initial begin
        logic        ov, co, ovf, ird, v, ordy, rci, rsub, stall_prev;
        logic [31:0] s, ra, rb;
        logic [34:0] prev_out;
        int          sent, got, cyc, bad_ready, bad_stable, stale;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            sample(i, ov, s, co, ovf, ird);
            check($sformatf("reset outputs d%0d", i), {29'h0, s, ov, co, ovf}, 64'h0);
            check($sformatf("reset in_ready d%0d", i), {63'h0, ird}, 64'h1);
        end
        reset = 1'b0;

        // 32/8: latency 4
        one_beat(0, "d32 add wrap",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4, 32'h0000_0000, 1'b1, 1'b0);
        one_beat(0, "d32 sub 5-7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one_beat(0, "d32 sub min-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4, 32'h7FFF_FFFF, 1'b1, 1'b1);
        one_beat(0, "d32 add max+1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4, 32'h8000_0000, 1'b0, 1'b1);
        one_beat(0, "d32 sub ci ign",32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 4, 32'h0000_0000, 1'b1, 1'b0);
        // 16/16: latency 1
        one_beat(1, "d16 add wrap",  32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        one_beat(1, "d16 sub 5-7",   32'h5, 32'h7, 1'b0, 1'b1, 1, 32'h0000_FFFE, 1'b0, 1'b0);
        one_beat(1, "d16 sub min-1", 32'h8000, 32'h1, 1'b0, 1'b1, 1, 32'h0000_7FFF, 1'b1, 1'b1);
        // 12/3: latency 4
        one_beat(2, "d12 add wrap",  32'h0000_0FFF, 32'h0, 1'b1, 1'b0, 4, 32'h0000_0000, 1'b1, 1'b0);
        one_beat(2, "d12 sub 5-7",   32'h5, 32'h7, 1'b0, 1'b1, 4, 32'h0000_0FFE, 1'b0, 1'b0);
        one_beat(2, "d12 sub min-1", 32'h800, 32'h1, 1'b0, 1'b1, 4, 32'h0000_07FF, 1'b1, 1'b1);

        // Random stream with random in_valid and out_ready on the 32/8 instance.
        sent = 0; got = 0; cyc = 0; bad_ready = 0; bad_stable = 0;
        stall_prev = 1'b0; prev_out = '0;
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            v    = (sent < 100) && ($urandom_range(0, 3) != 0);
            ra   = $urandom;
            rb   = $urandom;
            rci  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 2) != 0);
            drive(0, v, ra, rb, rci, rsub, ordy);
            #1;
            sample(0, ov, s, co, ovf, ird);
            if (stall_prev && ({ov, s, co, ovf} !== prev_out)) bad_stable++;
            if (!ird && !(ov && !ordy)) bad_ready++;
            if (v && ird) begin
                exp_q.push_back(model32(ra, rb, rci, rsub));
                sent++;
            end
            if (ov && ordy) begin
                if (exp_q.size() == 0) check("stream extra beat", {63'h0, ov}, 64'h0);
                else check($sformatf("stream beat %0d", got), {30'h0, s, co, ovf}, {30'h0, exp_q.pop_front()});
                got++;
            end
            stall_prev = ov && !ordy;
            prev_out   = {ov, s, co, ovf};
        end
        check("stream timeout", {63'h0, (cyc < 3000)}, 64'h1);
        check("stream count", 64'(got), 64'd100);
        check("stream in_ready", 64'(bad_ready), 64'h0);
        check("stream stall hold", 64'(bad_stable), 64'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            sample(0, ov, s, co, ovf, ird);
            if (ov) stale++;
        end
        check("stream no duplicates", 64'(stale), 64'h0);
        check("stream queue empty", 64'(exp_q.size()), 64'h0);

        // Fill the 32/8 pipe, then reset: everything in flight is flushed.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'(i * 3 + 1), 32'(i), 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        sample(0, ov, s, co, ovf, ird);
        check("flush pipe full", {63'h0, ov}, 64'h1);
        reset = 1'b1;
        #1;
        sample(0, ov, s, co, ovf, ird);
        check("flush out_valid", {63'h0, ov}, 64'h0);
        check("flush outputs", {30'h0, s, co, ovf}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            sample(0, ov, s, co, ovf, ird);
            if (ov) stale++;
        end
        check("flush no stale", 64'(stale), 64'h0);
        check("flush in_ready", {63'h0, ird}, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
